dispatch_queue: RTL
===================

Name: dispatch_queue

Overview:
- Parametrised, buffered successor to the single-entry dispatcher.
- Accepts decoded instructions from the decoder into a DEPTH-entry FIFO and resolves source operands at the FIFO head.
- Resolution sources: register-file status, ROB ready values, and NUM_CDB broadcast channels.
- Issues one instruction per cycle to the ROB plus either the RS or the LSB, with ready/valid back-pressure and a mispredict flush.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
NUM_CDB, 2, number of CDB broadcast channels snooped
ROB_W, 4, ROB index width
DATA_W, 32, data/immediate width
ADDR_W, 32, PC width
OPE_W, 6, instruction-type code width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global stall; when low, no state changes
flush  in  1  mispredict; clears the queue
in_valid  in  1  decoded instruction present
in_ready  out  1  queue can accept
in_type/in_rd/in_rs1/in_rs2  in  OPE_W/5/5/5  decoded fields
in_imm/in_pc/in_pred_pc  in  DATA_W/ADDR_W/ADDR_W  immediate, PC, predicted PC
in_pred_jump/in_is_mem  in  1/1  predicted taken; load/store class
rs1_to_reg/rs2_to_reg  out  5/5  head source indices (combinational)
v1_reg/v2_reg  in  DATA_W  register values
q1_busy/q2_busy  in  1  register renamed
q1_tag/q2_tag  in  ROB_W  producing ROB index
rob_v1_ready/rob_v2_ready  in  1  ROB entry for q*_tag completed
rob_v1/rob_v2  in  DATA_W  ROB entry values
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*ROB_W  flattened tags; channel i at [i*ROB_W +: ROB_W]
cdb_value  in  NUM_CDB*DATA_W  flattened values
rob_ready/rs_ready/lsb_ready  in  1  downstream has a free slot
rob_tail_id  in  ROB_W  ROB index assigned to the head
enable_to_rob/enable_to_rs/enable_to_lsb/enable_to_reg  out  1  one-cycle issue pulses
out_type/out_rd/out_imm/out_pc/out_pred_pc/out_pred_jump  out  —  registered head fields
out_vj/out_vk  out  DATA_W  resolved operands
out_qj_busy/out_qk_busy  out  1  operand still pending
out_qj/out_qk  out  ROB_W  pending tags
out_rob_id  out  ROB_W  ROB index, also the rename tag for out_rd

Behaviour:
- Reset (rst_n low, asynchronous):
  - pointers and count = 0; all enable_* = 0.
  - All data outputs = 0; in_ready = 1 after release.
- rdy low: all registers hold; enable_* forced 0 on the next edge.
- FIFO:
  - wr_ptr/rd_ptr of log2(DEPTH) bits wrap naturally; count ranges 0..DEPTH.
  - in_ready = (count < DEPTH) || fire.
  - Push on in_valid && in_ready. Simultaneous push and pop at full is legal and leaves count unchanged.
- Issue condition (fire): count > 0 && rob_ready && (in_is_mem_head ? lsb_ready : rs_ready).
- Operand resolution per source, combinational at the head, in priority order:
  1. q*_busy = 0: use v*_reg, not busy.
  2. Lowest-index CDB channel with cdb_valid[i] and tag match: its value, not busy.
  3. rob_v*_ready: rob_v*, not busy.
  4. Otherwise: busy, tag = q*_tag, value = 0.
- On fire, on the next edge:
  - register all out_* fields; out_rob_id = rob_tail_id.
  - pulse enable_to_rob.
  - pulse enable_to_lsb or enable_to_rs, exactly one.
  - pulse enable_to_reg only if out_rd != 0.
  - pop the head.
- Without fire, all enable_* = 0 and data outputs hold.
- Tags broadcast on CDB during the pulse cycle are snooped by the RS/LSB, not by this block.
- Flush:
  - On the next edge: count = 0, pointers = 0, enable_* = 0.
  - Overrides push and fire in the same cycle.
  - in_ready = 0 during the flush cycle.
- Stores (in_is_mem, rd field unused): decoder supplies rd = 0, so no rename.

Optional Feature:
DISPATCH_BYPASS_EN
- Defined: when count == 0 and in_valid, the incoming instruction is resolved and issued the same cycle if the fire conditions hold, and is not written to the FIFO. Issue latency is 1 cycle from acceptance.
- Undefined: every instruction is written first, giving a minimum latency of 2 cycles from acceptance to the enable pulse.

Test Plan:
- Reset then push ADD (rd=3, rs1=1 not busy, v1_reg=5; rs2 busy tag 2, ROB not ready); rs_ready=1 -> enable_to_rs=1, out_vj=5, out_qk_busy=1, out_qk=2, out_rob_id=rob_tail_id, enable_to_reg=1.
- Head rs1 busy tag 7; cdb_valid=2'b11, both channels tag 7, values 0xA and 0xB -> out_vj=0xA, out_qj_busy=0.
- Push 4 loads with lsb_ready=0 -> in_ready=0 after the 4th. Set lsb_ready=1 with in_valid held -> push and pop together, count stays 4, loads issue in order with enable_to_lsb.
- Queue holding 3 entries, flush=1 together with in_valid=1 -> no enables next cycle, count=0, the offered instruction is dropped.
- rdy=0 for 3 cycles with a ready head -> no enables, state unchanged. rdy=1 -> issue resumes on the next edge.
- Store SW with rd=0 -> enable_to_lsb=1, enable_to_reg=0. With DISPATCH_BYPASS_EN and an empty queue -> enable pulse 1 cycle after acceptance (2 cycles without the macro).

Source files
------------

// File: rtl/dispatch_queue.sv
// Buffered dispatcher: DEPTH-entry FIFO of decoded instructions, operand resolution at the head,
// single-cycle issue to ROB plus RS/LSB. Optional macro DISPATCH_BYPASS_EN lets an empty queue issue the incoming instruction directly.
module dispatch_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 2,
  parameter int ROB_W   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int OPE_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPE_W-1:0]          in_type,
  input  logic [4:0]                in_rd,
  input  logic [4:0]                in_rs1,
  input  logic [4:0]                in_rs2,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [ADDR_W-1:0]         in_pc,
  input  logic [ADDR_W-1:0]         in_pred_pc,
  input  logic                      in_pred_jump,
  input  logic                      in_is_mem,
  output logic [4:0]                rs1_to_reg,
  output logic [4:0]                rs2_to_reg,
  input  logic [DATA_W-1:0]         v1_reg,
  input  logic [DATA_W-1:0]         v2_reg,
  input  logic                      q1_busy,
  input  logic                      q2_busy,
  input  logic [ROB_W-1:0]          q1_tag,
  input  logic [ROB_W-1:0]          q2_tag,
  input  logic                      rob_v1_ready,
  input  logic                      rob_v2_ready,
  input  logic [DATA_W-1:0]         rob_v1,
  input  logic [DATA_W-1:0]         rob_v2,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  input  logic                      rob_ready,
  input  logic                      rs_ready,
  input  logic                      lsb_ready,
  input  logic [ROB_W-1:0]          rob_tail_id,
  output logic                      enable_to_rob,
  output logic                      enable_to_rs,
  output logic                      enable_to_lsb,
  output logic                      enable_to_reg,
  output logic [OPE_W-1:0]          out_type,
  output logic [4:0]                out_rd,
  output logic [DATA_W-1:0]         out_imm,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [ADDR_W-1:0]         out_pred_pc,
  output logic                      out_pred_jump,
  output logic [DATA_W-1:0]         out_vj,
  output logic [DATA_W-1:0]         out_vk,
  output logic                      out_qj_busy,
  output logic                      out_qk_busy,
  output logic [ROB_W-1:0]          out_qj,
  output logic [ROB_W-1:0]          out_qk,
  output logic [ROB_W-1:0]          out_rob_id
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [OPE_W-1:0]  ty;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_jump;
    logic              is_mem;
  } entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic              busy;
    logic [ROB_W-1:0]  q;
  } opnd_t;

  function automatic opnd_t resolve(
    input logic                      busy,
    input logic [ROB_W-1:0]          tag,
    input logic [DATA_W-1:0]         vreg,
    input logic                      robrdy,
    input logic [DATA_W-1:0]         robv,
    input logic [NUM_CDB-1:0]        cvalid,
    input logic [NUM_CDB*ROB_W-1:0]  ctag,
    input logic [NUM_CDB*DATA_W-1:0] cval
  );
    opnd_t o;
    logic  hit;
    o.v    = '0;
    o.busy = 1'b1;
    o.q    = tag;
    hit    = 1'b0;
    if (!busy) begin
      o.v    = vreg;
      o.busy = 1'b0;
      o.q    = '0;
    end else begin
      // Lowest channel wins when several broadcast the same tag.
      for (int unsigned i = 0; i < NUM_CDB; i++) begin
        if (!hit && cvalid[i] && ctag[i*ROB_W +: ROB_W] == tag) begin
          o.v = cval[i*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      end
      if (hit || robrdy) begin
        if (!hit) o.v = robv;
        o.busy = 1'b0;
        o.q    = '0;
      end
    end
    return o;
  endfunction

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  entry_t w_in_entry;
  entry_t w_head;
  logic   w_empty;
  logic   w_has_head;
  logic   w_fire;
  logic   w_push;
  logic   w_pop;
  opnd_t  w_op1;
  opnd_t  w_op2;

  assign w_in_entry = {in_type, in_rd, in_rs1, in_rs2, in_imm, in_pc, in_pred_pc,
                       in_pred_jump, in_is_mem};
  assign w_empty    = (r_count == '0);

`ifdef DISPATCH_BYPASS_EN
  assign w_has_head = !w_empty || in_valid;
  assign w_head     = w_empty ? w_in_entry : r_mem[r_rd_ptr];
`else
  assign w_has_head = !w_empty;
  assign w_head     = r_mem[r_rd_ptr];
`endif

  assign w_fire   = w_has_head && rob_ready && (w_head.is_mem ? lsb_ready : rs_ready);
  assign in_ready = rdy && !flush && ((r_count != FULL) || w_fire);
  // An instruction issued straight from the input (empty queue) is never stored.
  assign w_push   = in_valid && in_ready && !(w_empty && w_fire);
  assign w_pop    = rdy && !flush && w_fire && !w_empty;

  assign rs1_to_reg = w_head.rs1;
  assign rs2_to_reg = w_head.rs2;

  assign w_op1 = resolve(q1_busy, q1_tag, v1_reg, rob_v1_ready, rob_v1,
                         cdb_valid, cdb_tag, cdb_value);
  assign w_op2 = resolve(q2_busy, q2_tag, v2_reg, rob_v2_ready, rob_v2,
                         cdb_valid, cdb_tag, cdb_value);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      enable_to_rob <= 1'b0;
      enable_to_rs  <= 1'b0;
      enable_to_lsb <= 1'b0;
      enable_to_reg <= 1'b0;
      out_type      <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_pred_pc   <= '0;
      out_pred_jump <= 1'b0;
      out_vj        <= '0;
      out_vk        <= '0;
      out_qj_busy   <= 1'b0;
      out_qk_busy   <= 1'b0;
      out_qj        <= '0;
      out_qk        <= '0;
      out_rob_id    <= '0;
    end else if (!rdy) begin
      enable_to_rob <= 1'b0;
      enable_to_rs  <= 1'b0;
      enable_to_lsb <= 1'b0;
      enable_to_reg <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      enable_to_rob <= 1'b0;
      enable_to_rs  <= 1'b0;
      enable_to_lsb <= 1'b0;
      enable_to_reg <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      enable_to_rob <= w_fire;
      enable_to_rs  <= w_fire && !w_head.is_mem;
      enable_to_lsb <= w_fire && w_head.is_mem;
      enable_to_reg <= w_fire && (w_head.rd != 5'd0);
      if (w_fire) begin
        out_type      <= w_head.ty;
        out_rd        <= w_head.rd;
        out_imm       <= w_head.imm;
        out_pc        <= w_head.pc;
        out_pred_pc   <= w_head.pred_pc;
        out_pred_jump <= w_head.pred_jump;
        out_vj        <= w_op1.v;
        out_vk        <= w_op2.v;
        out_qj_busy   <= w_op1.busy;
        out_qk_busy   <= w_op2.busy;
        out_qj        <= w_op1.q;
        out_qk        <= w_op2.q;
        out_rob_id    <= rob_tail_id;
      end
    end
  end

endmodule
